// File: rtl/sonar_transmissor_quadro.sv
// ---------------------------------------------------------------------------
// sonar_transmissor_quadro
// Serial framing stage for the sonar. A partida pulse latches the servo angle
// and the measured distance (three BCD digits each), then the block sends the
// ASCII frame "AAA,DDD#" through a built-in UART transmitter.
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous, active-high
//   partida          start request, honoured only while idle (INICIAL)
//   angulo_*         BCD angle digits (hundreds, tens, units)
//   medida_*         BCD distance digits (hundreds, tens, units)
//   saida_serial     UART line, idle high, LSB first
//   ocupado          high whenever the FSM is not in INICIAL
//   pronto           one-cycle pulse once the whole frame is sent
//   db_estado        FSM state code for a debug display
//
// Configuration macro: SONAR_TX_PARIDADE_EN
//   defined   -> 7E2 (start, 7 data, even parity, 2 stop), 11 bits per char
//   undefined -> 8N1 (start, 8 data, 1 stop), 10 bits per char
// ---------------------------------------------------------------------------
module sonar_transmissor_quadro #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [3:0] angulo_centena,
    input  logic [3:0] angulo_dezena,
    input  logic [3:0] angulo_unidade,
    input  logic [3:0] medida_centena,
    input  logic [3:0] medida_dezena,
    input  logic [3:0] medida_unidade,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

`ifdef SONAR_TX_PARIDADE_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        PREPARA   = 4'd1,
        CARREGA   = 4'd2,
        TRANSMITE = 4'd3,
        PROXIMO   = 4'd4,
        FIM       = 4'd5
    } t_estado;

    t_estado              r_estado;
    t_estado              w_prox;
    logic [5:0][3:0]      r_dig;      // [5] = angle hundreds ... [0] = distance units
    logic [2:0]           r_idx;
    logic [NBITS-1:0]     r_shift;
    logic [3:0]           r_bit;
    logic [15:0]          r_baud;
    logic [7:0]           w_char;
    logic [NBITS-1:0]     w_frame;
    logic                 w_baud_wrap;
    logic                 w_last_bit;

    // Digits above 9 are not representable, so they go out as '?'.
    function automatic logic [7:0] f_ascii(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    always_comb begin
        w_char = 8'h23;
        case (r_idx)
            3'd0: w_char = f_ascii(r_dig[5]);
            3'd1: w_char = f_ascii(r_dig[4]);
            3'd2: w_char = f_ascii(r_dig[3]);
            3'd3: w_char = 8'h2C;
            3'd4: w_char = f_ascii(r_dig[2]);
            3'd5: w_char = f_ascii(r_dig[1]);
            3'd6: w_char = f_ascii(r_dig[0]);
            default: w_char = 8'h23;
        endcase
    end

    // Shift register image, bit 0 goes on the line first (start bit).
`ifdef SONAR_TX_PARIDADE_EN
    assign w_frame = {2'b11, ^w_char[6:0], w_char[6:0], 1'b0};
`else
    assign w_frame = {1'b1, w_char, 1'b0};
`endif

    assign w_baud_wrap = (r_baud == 16'(BAUD_DIV - 1));
    assign w_last_bit  = (r_bit == 4'(NBITS - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_estado <= INICIAL;
        else       r_estado <= w_prox;
    end

    // Next-state logic
    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:   if (partida) w_prox = PREPARA;
            PREPARA:   w_prox = CARREGA;
            CARREGA:   w_prox = TRANSMITE;
            TRANSMITE: if (w_baud_wrap && w_last_bit) w_prox = PROXIMO;
            PROXIMO:   w_prox = (r_idx == 3'd7) ? FIM : CARREGA;
            FIM:       w_prox = INICIAL;
            default:   w_prox = INICIAL;
        endcase
    end

    // Datapath: digit latch, character index, bit/baud counters, shifter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dig   <= '0;
            r_idx   <= '0;
            r_shift <= '1;
            r_bit   <= '0;
            r_baud  <= '0;
        end else begin
            case (r_estado)
                INICIAL: if (partida)
                    r_dig <= {angulo_centena, angulo_dezena, angulo_unidade,
                              medida_centena, medida_dezena, medida_unidade};
                PREPARA: r_idx <= '0;
                CARREGA: begin
                    r_shift <= w_frame;
                    r_bit   <= '0;
                    r_baud  <= '0;
                end
                TRANSMITE: begin
                    if (w_baud_wrap) begin
                        r_baud  <= '0;
                        r_shift <= {1'b1, r_shift[NBITS-1:1]};
                        r_bit   <= r_bit + 4'd1;
                    end else begin
                        r_baud  <= r_baud + 16'd1;
                    end
                end
                PROXIMO: if (r_idx != 3'd7) r_idx <= r_idx + 3'd1;
                default: ;
            endcase
        end
    end

    // Line is driven from the shifter only while transmitting; the inter-char
    // gap (PROXIMO, CARREGA) and idle both read as stop/idle level.
    assign saida_serial = (r_estado == TRANSMITE) ? r_shift[0] : 1'b1;
    assign ocupado      = (r_estado != INICIAL);
    assign pronto       = (r_estado == FIM);
    assign db_estado    = r_estado;

endmodule

// File: tb/tb_sonar_transmissor_quadro.sv
module tb_sonar_transmissor_quadro;

    localparam int B = 4;
`ifdef SONAR_TX_PARIDADE_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int P   = NB * B + 2;       // cycles per character incl. gap
    localparam int F   = 18 + 8 * NB * B;  // pronto offset from partida cycle
    localparam int LEN = F + 4;

    logic       clock = 1'b0;
    logic       reset, partida;
    logic [3:0] ac, ad, au, mc, md, mu;
    logic       saida_serial, ocupado, pronto;
    logic [3:0] db_estado;

    sonar_transmissor_quadro #(.BAUD_DIV(B)) dut (
        .clock(clock), .reset(reset), .partida(partida),
        .angulo_centena(ac), .angulo_dezena(ad), .angulo_unidade(au),
        .medida_centena(mc), .medida_dezena(md), .medida_unidade(mu),
        .saida_serial(saida_serial), .ocupado(ocupado), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic       cap_line [0:LEN];
    logic       cap_pr   [0:LEN];
    logic       cap_oc   [0:LEN];
    logic [3:0] cap_st   [0:LEN];

    typedef struct {
        logic [23:0] dig;   // ang C,D,U, dist C,D,U
        logic [63:0] exp;   // char 0 in [63:56]
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference: frame characters from the digit rules
    function automatic logic [7:0] ref_char(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
    endfunction

    function automatic logic [63:0] ref_frame(input logic [23:0] dig);
        logic [63:0] f;
        f = {ref_char(dig[23:20]), ref_char(dig[19:16]), ref_char(dig[15:12]), 8'h2C,
             ref_char(dig[11:8]),  ref_char(dig[7:4]),   ref_char(dig[3:0]),   8'h23};
        return f;
    endfunction

    // Line level of bit slot b of a character
    function automatic logic exp_bit(input logic [7:0] ch, input int b);
        if (b == 0) return 1'b0;
`ifdef SONAR_TX_PARIDADE_EN
        if (b <= 7) return ch[b-1];
        if (b == 8) return ^ch[6:0];
`else
        if (b <= 8) return ch[b-1];
`endif
        return 1'b1;
    endfunction

    // Expected line at cycle T+k
    function automatic logic exp_line(input logic [63:0] fr, input int k);
        int j, c, r;
        if (k < 3) return 1'b1;
        j = k - 3;
        c = j / P;
        r = j % P;
        if (c >= 8 || r >= NB * B) return 1'b1;
        return exp_bit(fr[63 - 8*c -: 8], r / B);
    endfunction

    task automatic run_frame(input logic [23:0] dig, input logic [63:0] fr,
                             input bit disturb, input string tag);
        int mism, first_bad, npr, firstpr, oc_bad, i;
        logic [7:0] val;
        @(negedge clock);
        {ac, ad, au, mc, md, mu} = dig;
        partida = 1'b1;
        check({tag, ".idle_ocupado"}, 32'(ocupado), 32'd0);
        for (int k = 1; k <= LEN; k++) begin
            @(negedge clock);
            cap_line[k] = saida_serial;
            cap_pr[k]   = pronto;
            cap_oc[k]   = ocupado;
            cap_st[k]   = db_estado;
            if (k == 1) partida = 1'b0;
            if (disturb && k == 100) begin
                {ac, ad, au, mc, md, mu} = ~dig;
                partida = 1'b1;
            end
            if (disturb && k == 101) partida = 1'b0;
        end
        // cycle-accurate waveform
        mism = 0; first_bad = -1;
        for (int k = 1; k <= LEN; k++)
            if (cap_line[k] !== exp_line(fr, k)) begin
                mism++;
                if (first_bad < 0) first_bad = k;
            end
        if (mism != 0) $display("  %s first line difference at T+%0d", tag, first_bad);
        check({tag, ".wave_diffs"}, 32'(mism), 32'd0);
        // pronto
        npr = 0; firstpr = -1;
        for (int k = 1; k <= LEN; k++)
            if (cap_pr[k] === 1'b1) begin
                npr++;
                if (firstpr < 0) firstpr = k;
            end
        check({tag, ".pronto_at"}, 32'(firstpr), 32'(F));
        check({tag, ".pronto_count"}, 32'(npr), 32'd1);
        // ocupado high through FIM, low after
        oc_bad = 0;
        for (int k = 1; k <= LEN; k++)
            if (cap_oc[k] !== (k <= F)) oc_bad++;
        check({tag, ".ocupado_profile"}, 32'(oc_bad), 32'd0);
        check({tag, ".st1"}, 32'(cap_st[1]), 32'd1);
        check({tag, ".st2"}, 32'(cap_st[2]), 32'd2);
        check({tag, ".st3"}, 32'(cap_st[3]), 32'd3);
        check({tag, ".stF"}, 32'(cap_st[F]), 32'd5);
        check({tag, ".stF1"}, 32'(cap_st[F+1]), 32'd0);
        // UART receiver: find start edge, sample mid-bit
        i = 1;
        for (int c = 0; c < 8; c++) begin
            while (i <= LEN && cap_line[i] !== 1'b0) i++;
            check({tag, ".start_found"}, 32'(i + NB*B <= LEN), 32'd1);
            if (i + NB*B > LEN) break;
            val = 8'h00;
`ifdef SONAR_TX_PARIDADE_EN
            for (int b = 0; b < 7; b++) val[b] = cap_line[i + B/2 + (b+1)*B];
            check($sformatf("%s.char%0d", tag, c), 32'(val), 32'(fr[63-8*c -: 8] & 8'h7F));
            check($sformatf("%s.par%0d", tag, c), 32'(cap_line[i + B/2 + 8*B]),
                  32'(^fr[62-8*c -: 7]));
            check($sformatf("%s.stop%0d", tag, c),
                  32'({cap_line[i + B/2 + 9*B], cap_line[i + B/2 + 10*B]}), 32'd3);
`else
            for (int b = 0; b < 8; b++) val[b] = cap_line[i + B/2 + (b+1)*B];
            check($sformatf("%s.char%0d", tag, c), 32'(val), 32'(fr[63-8*c -: 8]));
            check($sformatf("%s.stop%0d", tag, c), 32'(cap_line[i + B/2 + 9*B]), 32'd1);
`endif
            i = i + NB*B;
        end
    endtask

    vec_t tbl [3];

    initial begin
        logic [23:0] rd;
        tbl[0] = '{dig: 24'h090025, exp: 64'h3039302C30323523};
        tbl[1] = '{dig: 24'hB12345, exp: 64'h3F31322C33343523};
        tbl[2] = '{dig: 24'h999F0A, exp: 64'h3939392C3F303F23};

        reset = 1'b1; partida = 1'b0;
        {ac, ad, au, mc, md, mu} = 24'h0;
        repeat (3) @(negedge clock);
        check("reset.line", 32'(saida_serial), 32'd1);
        check("reset.ocupado", 32'(ocupado), 32'd0);
        check("reset.pronto", 32'(pronto), 32'd0);
        check("reset.estado", 32'(db_estado), 32'd0);
        reset = 1'b0;

        // table vectors
        for (int v = 0; v < 3; v++)
            run_frame(tbl[v].dig, tbl[v].exp, 1'b0, $sformatf("vec%0d", v));

        // inputs changed and partida re-pulsed mid-frame: frame content frozen
        run_frame(tbl[0].dig, tbl[0].exp, 1'b1, "disturb");
        repeat (20) @(negedge clock);
        check("disturb.no_second_frame", 32'({ocupado, saida_serial}), 32'b01);

        // reset during character 4
        @(negedge clock);
        {ac, ad, au, mc, md, mu} = tbl[1].dig;
        partida = 1'b1;
        @(negedge clock);
        partida = 1'b0;
        repeat (2 + 4*P + 10) @(negedge clock);
        check("midreset.transmitting", 32'(db_estado), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        check("midreset.line", 32'(saida_serial), 32'd1);
        check("midreset.ocupado", 32'(ocupado), 32'd0);
        check("midreset.estado", 32'(db_estado), 32'd0);
        check("midreset.pronto", 32'(pronto), 32'd0);
        reset = 1'b0;
        run_frame(tbl[1].dig, tbl[1].exp, 1'b0, "after_reset");

        // partida held high: back in INICIAL for one cycle, then a new frame
        @(negedge clock);
        {ac, ad, au, mc, md, mu} = tbl[2].dig;
        partida = 1'b1;
        for (int k = 1; k <= F + 2; k++) begin
            @(negedge clock);
            cap_st[k] = db_estado;
            cap_pr[k] = pronto;
        end
        partida = 1'b0;
        check("hold.pronto", 32'(cap_pr[F]), 32'd1);
        check("hold.inicial", 32'(cap_st[F+1]), 32'd0);
        check("hold.retrigger", 32'(cap_st[F+2]), 32'd1);
        repeat (LEN) @(negedge clock);
        check("hold.second_done", 32'(ocupado), 32'd0);

        // randomized frames against the reference model
        for (int r = 0; r < 6; r++) begin
            rd = 24'($urandom);
            run_frame(rd, ref_frame(rd), 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
